// File: rtl/ann_weight_pkg.sv
// Shared defaults and FSM encoding for the neuron weight BRAM reader.
package ann_weight_pkg;

   localparam int DEPTH_DEF    = 28;
   localparam int AW_DEF       = 5;
   localparam int DW_DEF       = 16;
   localparam int FIFO_ENTRIES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } rd_state_e;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO between the BRAM read port and the weight stream; head is always visible.
module weight_skid_fifo
   import ann_weight_pkg::*;
#(
   parameter int W = 22
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         valid,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [FIFO_ENTRIES];
   logic [W-1:0] mem_d [FIFO_ENTRIES];
   logic         wr_q, wr_d;
   logic         rd_q, rd_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_push, do_pop;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      do_pop  = pop && (cnt_q != 2'd0);
      // A full FIFO may still take a word when the head leaves in the same cycle.
      do_push = push && ((cnt_q != 2'(FIFO_ENTRIES)) || do_pop);
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = ~wr_q;
      end
      if (do_pop) begin
         rd_d = ~rd_q;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_ENTRIES; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign valid = (cnt_q != 2'd0);
   assign head  = mem_q[rd_q];
   assign count = cnt_q;

endmodule

// File: rtl/weight_bram_reader.sv
// Streams all DEPTH weight words of one neuron memory out of a read-only BRAM
// as a valid/ready stream, tagging each word with its address and a last flag.
module weight_bram_reader
   import ann_weight_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          START,
   output logic          BUSY,
   output logic          DONE,
   output logic [AW-1:0] ADDR,
   output logic          EN,
   output logic          WE,
   output logic [DW-1:0] DI,
   input  logic [DW-1:0] DO,
   output logic          W_VALID,
   input  logic          W_READY,
   output logic [DW-1:0] W_DATA,
   output logic [AW-1:0] W_IDX,
   output logic          W_LAST
);

   localparam int          FW        = DW + AW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   rd_state_e     state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          issue;
   logic          done_d;
   logic          fifo_valid;
   logic [FW-1:0] fifo_head;
   logic [1:0]    fifo_count;
   logic [FW-1:0] push_word;
   logic          accept;

   assign accept = fifo_valid && W_READY;

   // The BRAM samples on the falling edge and returns data before the next rising
   // edge, so a read never outlives its issue cycle: occupancy alone bounds issue.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      issue   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = FETCH;
               ptr_d   = '0;
            end
         end
         FETCH: begin
            issue = (fifo_count < 2'(FIFO_ENTRIES));
            if (issue) begin
               if (ptr_q == LAST_ADDR) begin
                  state_d = DRAIN;
               end else begin
                  ptr_d = ptr_q + AW'(1);
               end
            end
         end
         DRAIN: begin
            if (accept && fifo_head[FW-1]) begin
               state_d = FIN;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign push_word = {(ptr_q == LAST_ADDR), ptr_q, DO};

   weight_skid_fifo #(
      .W(FW)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (issue),
      .push_data (push_word),
      .pop       (accept),
      .valid     (fifo_valid),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign EN      = issue;
   assign ADDR    = issue ? ptr_q : '0;
   assign WE      = 1'b0;
   assign DI      = '0;
   assign BUSY    = (state_q != IDLE);
   assign DONE    = done_d;
   assign W_VALID = fifo_valid;
   assign {W_LAST, W_IDX, W_DATA} = fifo_valid ? fifo_head : '0;

endmodule

// File: tb/tb_weight_bram_reader.sv
// Scoreboard bench for weight_bram_reader: directed transfers against a negedge BRAM model.
module tb_weight_bram_reader;

   localparam int DEPTH = 28;
   localparam int AW    = 5;
   localparam int DW    = 16;

   typedef logic [AW+DW:0] word_t;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          START, W_READY;
   logic          BUSY, DONE, EN, WE, W_VALID, W_LAST;
   logic [AW-1:0] ADDR, W_IDX;
   logic [DW-1:0] DI, DO, W_DATA;

   logic          START1, W_READY1;
   logic          BUSY1, DONE1, EN1, WE1, W_VALID1, W_LAST1;
   logic [AW-1:0] ADDR1, W_IDX1;
   logic [DW-1:0] DI1, DO1, W_DATA1;

   logic [DW-1:0] mem [0:31];
   word_t         exp_q[$];

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int acc_cnt = 0;
   int streak = 0;
   int last_streak = 0;
   logic  done_due = 1'b0;
   logic  prev_stall = 1'b0;
   word_t prev_word = '0;

   always #5 CLK = ~CLK;

   weight_bram_reader dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(BUSY), .DONE(DONE),
      .ADDR(ADDR), .EN(EN), .WE(WE), .DI(DI), .DO(DO),
      .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_IDX(W_IDX), .W_LAST(W_LAST)
   );

   weight_bram_reader #(.DEPTH(1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .START(START1), .BUSY(BUSY1), .DONE(DONE1),
      .ADDR(ADDR1), .EN(EN1), .WE(WE1), .DI(DI1), .DO(DO1),
      .W_VALID(W_VALID1), .W_READY(W_READY1), .W_DATA(W_DATA1), .W_IDX(W_IDX1), .W_LAST(W_LAST1)
   );

   // BRAM models: address/enable sampled on the falling edge, registered data out.
   always @(negedge CLK) begin
      if (EN) DO <= mem[ADDR];
      if (EN1) DO1 <= (ADDR1 == '0) ? 16'hBEEF : 16'hDEAD;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted word, checks stall hold and DONE timing.
   always @(negedge CLK) begin
      if (!RST_N) begin
         prev_stall = 1'b0;
         done_due   = 1'b0;
         streak     = 0;
      end else begin
         if (done_due || DONE) chk("done_pulse", 32'(DONE), 32'(done_due));
         if (DONE) done_cnt++;
         done_due = 1'b0;
         if (prev_stall) chk("stall_hold", 32'({W_VALID, W_LAST, W_IDX, W_DATA}), 32'({1'b1, prev_word}));
         if (W_VALID && W_READY) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'({W_LAST, W_IDX, W_DATA}), 32'hFFFF_FFFF);
            end else begin
               chk("word", 32'({W_LAST, W_IDX, W_DATA}), 32'(exp_q.pop_front()));
            end
            acc_cnt++;
            streak++;
            if (W_LAST) begin
               last_streak = streak;
               done_due    = 1'b1;
            end
         end else begin
            streak = 0;
         end
         prev_stall = W_VALID && !W_READY;
         prev_word  = {W_LAST, W_IDX, W_DATA};
      end
   end

   task automatic load_mem(input int kind);
      for (int i = 0; i < 32; i++) begin
         case (kind)
            0:       mem[i] = 16'(i);
            1:       mem[i] = 16'hC000 + 16'(i * 16'h0101);
            default: mem[i] = 16'h5A5A ^ 16'((i << 8) | (i * 3));
         endcase
      end
   endtask

   task automatic start_xfer();
      @(posedge CLK);
      #1 START = 1'b1;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), AW'(i), mem[i]});
      @(posedge CLK);
      #1 START = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int base = done_cnt;
      int n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge CLK);
         n++;
      end
      chk("done_seen", 32'(done_cnt - base), 32'd1);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"},  32'(BUSY),    32'd0);
      chk({tag, "_done"},  32'(DONE),    32'd0);
      chk({tag, "_en"},    32'(EN),      32'd0);
      chk({tag, "_addr"},  32'(ADDR),    32'd0);
      chk({tag, "_valid"}, 32'(W_VALID), 32'd0);
      chk({tag, "_data"},  32'(W_DATA),  32'd0);
      chk({tag, "_idx"},   32'(W_IDX),   32'd0);
      chk({tag, "_last"},  32'(W_LAST),  32'd0);
      chk({tag, "_we_di"}, 32'({WE, DI}), 32'd0);
   endtask

   initial begin
      int base;
      int en_cnt;
      int n;
      RST_N = 1'b1; START = 1'b0; W_READY = 1'b0; START1 = 1'b0; W_READY1 = 1'b1;
      load_mem(0);
      #2 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      chk_quiet("reset");
      chk("reset_dut1", 32'({BUSY1, DONE1, EN1, WE1, DI1, W_VALID1, W_LAST1, W_IDX1, W_DATA1}), 32'd0);
      RST_N = 1'b1;

      // Full-rate stream: first word two cycles after START, 28 back-to-back words.
      W_READY = 1'b1;
      start_xfer();
      @(negedge CLK);
      chk("c1_busy", 32'(BUSY), 32'd1);
      chk("c1_en_addr", 32'({EN, ADDR}), 32'({1'b1, 5'd0}));
      chk("c1_valid", 32'(W_VALID), 32'd0);
      @(negedge CLK);
      chk("c2_valid", 32'(W_VALID), 32'd1);
      wait_done(60);
      chk("back_to_back", 32'(last_streak), 32'(DEPTH));
      chk("drained1", 32'(exp_q.size()), 32'd0);

      // Ready pattern 1,0,0,1 repeating.
      load_mem(1);
      start_xfer();
      base = done_cnt;
      n = 0;
      while (done_cnt == base && n < 300) begin
         @(posedge CLK);
         #1 W_READY = (n % 4 == 0) || (n % 4 == 3);
         @(negedge CLK);
         n++;
      end
      chk("done_toggle", 32'(done_cnt - base), 32'd1);
      chk("drained2", 32'(exp_q.size()), 32'd0);

      // Held stall: at most the two buffer slots get read.
      W_READY = 1'b0;
      load_mem(2);
      start_xfer();
      en_cnt = 0;
      repeat (10) begin
         @(negedge CLK);
         if (EN) en_cnt++;
      end
      chk("stall_reads", 32'(en_cnt), 32'd2);
      chk("stall_valid", 32'(W_VALID), 32'd1);
      @(posedge CLK);
      #1 W_READY = 1'b1;
      wait_done(60);
      chk("drained3", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a transfer, then a clean restart from index 0.
      base = acc_cnt;
      start_xfer();
      n = 0;
      while ((acc_cnt - base) < 13 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("reached_word13", 32'(acc_cnt - base >= 13), 32'd1);
      #2 RST_N = 1'b0;
      #1 chk_quiet("midreset");
      exp_q.delete();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      chk("post_reset_idle", 32'({BUSY, W_VALID}), 32'd0);
      start_xfer();
      wait_done(60);
      chk("drained4", 32'(exp_q.size()), 32'd0);

      // START while busy must be ignored.
      base = done_cnt;
      start_xfer();
      repeat (5) @(posedge CLK);
      #1 START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      wait_done(60);
      repeat (40) @(negedge CLK);
      chk("single_done", 32'(done_cnt - base), 32'd1);
      chk("drained5", 32'(exp_q.size()), 32'd0);

      // Single-word memory build.
      @(posedge CLK);
      #1 START1 = 1'b1;
      @(posedge CLK);
      #1 START1 = 1'b0;
      @(negedge CLK);
      chk("d1_c1_en", 32'({EN1, ADDR1, W_VALID1}), 32'({1'b1, 5'd0, 1'b0}));
      @(negedge CLK);
      chk("d1_word", 32'({W_VALID1, W_LAST1, W_IDX1, W_DATA1}), 32'({1'b1, 1'b1, 5'd0, 16'hBEEF}));
      @(negedge CLK);
      chk("d1_done", 32'({DONE1, W_VALID1}), 32'({1'b1, 1'b0}));
      @(negedge CLK);
      chk("d1_idle", 32'({DONE1, BUSY1}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/weight_bram_reader.md
WEIGHT_BRAM_READER -- requirements
Module: weight_bram_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 28, number of weight words per neuron memory.
REQ-002 SHALL have parameter AW, default 5, BRAM address width.
REQ-003 SHALL have parameter DW, default 16, weight word width.
REQ-004 SHALL have port CLK  in  1  single clock; all logic on posedge CLK.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port START  in  1  one-cycle pulse; begin streaming all DEPTH words.
REQ-007 SHALL have port BUSY  out  1  high from the cycle after an accepted START until DONE.
REQ-008 SHALL have port DONE  out  1  one-cycle pulse after the last word is accepted downstream.
REQ-009 SHALL have port ADDR  out  AW  BRAM read address.
REQ-010 SHALL have port EN  out  1  BRAM enable.
REQ-011 SHALL have port WE  out  1  BRAM write enable, tied 0.
REQ-012 SHALL have port DI  out  DW  BRAM write data, tied 0.
REQ-013 SHALL have port DO  in  DW  BRAM registered read data; BRAM samples ADDR/EN on negedge CLK.
REQ-014 SHALL have port W_VALID  out  1  output word valid.
REQ-015 SHALL have port W_READY  in  1  downstream accepts when W_VALID and W_READY are both high.
REQ-016 SHALL have port W_DATA  out  DW  weight word.
REQ-017 SHALL have port W_IDX  out  AW  address the word came from.
REQ-018 SHALL have port W_LAST  out  1  high with the word at index DEPTH-1.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DRAIN, FIN.
REQ-020 IDLE: START=1 -> FETCH, read pointer 0; START ignored in all other states.
REQ-021 FETCH: EN=1 with ADDR=read pointer only when (buffer occupancy + in-flight reads) < 2; the pointer increments on each issue.
REQ-022 DO SHALL be captured into the buffer at the posedge following the issue cycle (1-cycle read latency), tagged with the issued address.
REQ-023 The buffer SHALL be a 2-entry FIFO; W_VALID = not empty; head drives W_DATA/W_IDX/W_LAST.
REQ-024 Simultaneous capture and downstream accept in the same cycle SHALL keep occupancy unchanged, with no word lost or duplicated.
REQ-025 After address DEPTH-1 is issued: FETCH -> DRAIN; no further EN.
REQ-026 DRAIN -> FIN when the W_LAST word is accepted; FIN asserts DONE for one cycle -> IDLE.
REQ-027 With W_READY held high, SHALL sustain one word per cycle; the first W_VALID appears 2 cycles after START.
REQ-028 W_DATA/W_IDX/W_LAST SHALL hold stable while W_VALID=1 and W_READY=0.
REQ-029 The read pointer SHALL never exceed DEPTH-1 and SHALL never wrap within a transfer.
REQ-030 EN SHALL be 0 in IDLE, DRAIN and FIN.

Reset
REQ-031 RST_N=0 SHALL asynchronously force IDLE, pointer 0, buffer empty, and in-flight count 0.
REQ-032 Output values during reset: BUSY=0, DONE=0, EN=0, ADDR=0, W_VALID=0, W_DATA=0, W_IDX=0, W_LAST=0.
REQ-033 Reset mid-transfer SHALL discard buffered and in-flight words; a DO return arriving after reset SHALL be ignored.

Structure
REQ-034 DEPTH/AW/DW defaults and the FSM state encoding SHALL live in a shared package, ann_weight_pkg.
REQ-035 The 2-entry FIFO SHALL be the one sub-module, weight_skid_fifo.

Verification
REQ-036 Memory loaded 0x0000..0x001B, W_READY=1, START pulse -> 28 words, W_IDX 0..27 on consecutive cycles, W_LAST on idx 27, DONE 1 cycle after.
REQ-037 W_READY toggling 1,0,0,1 repeatedly -> same 28 words in order, none dropped or duplicated, W_DATA stable while stalled.
REQ-038 W_READY=0 for 10 cycles after START -> at most 2 issued reads, EN low until a word is accepted.
REQ-039 RST_N low at word 13 -> all outputs 0 within the reset cycle; a new START restarts at W_IDX 0.
REQ-040 START pulsed while BUSY=1 -> ignored; exactly 28 words and one DONE.
REQ-041 DEPTH=1 build -> single word with W_LAST=1, then DONE.
